// File: rtl/halt_dump_controller_if.sv
// Data-memory read port and dump output stream shared by halt_dump_controller
// and the memory/consumer side.
interface halt_dump_controller_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              mem_own;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic [DATA_W-1:0] out_data;

    modport master (
        output mem_own,
        output mem_addr,
        input  mem_rdata,
        output out_valid,
        input  out_ready,
        output out_addr,
        output out_data
    );

    modport slave (
        input  mem_own,
        input  mem_addr,
        output mem_rdata,
        input  out_valid,
        output out_ready,
        input  out_addr,
        input  out_data
    );
endinterface

// File: rtl/halt_dump_controller.sv
// End-of-program sequencer: halt detect, pipeline drain, then memory window dump.
// Optional macro DUMP_ZERO_SKIP_EN drops zero words from the dump stream.
module halt_dump_controller #(
    parameter int                ADDR_W       = 16,
    parameter int                DATA_W       = 16,
    parameter int                DRAIN_CYCLES = 10,
    parameter logic [DATA_W-1:0] HALT_OP0     = 16'hE000,
    parameter logic [DATA_W-1:0] HALT_OP1     = 16'hE7FF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] instr,
    input  logic              instr_valid,
    input  logic [ADDR_W-1:0] dump_base,
    input  logic [ADDR_W-1:0] dump_count,
    output logic              cpu_stall,
    output logic              halted,
    output logic              done,
    halt_dump_controller_if.master dbus
);

    typedef enum logic [2:0] {
        S_RUN   = 3'd0,
        S_DRAIN = 3'd1,
        S_READ  = 3'd2,
        S_WAIT  = 3'd3,
        S_EMIT  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t            state, state_nxt;
    logic [7:0]        drain_cnt;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] rem_cnt;
    logic [ADDR_W-1:0] out_addr_r;
    logic [DATA_W-1:0] out_data_r;
    logic              halted_r;

    logic halt_hit;
    logic last_word;
    logic skip_word;
    logic handshake;
    logic advance;

    assign halt_hit  = instr_valid && ((instr == HALT_OP0) || (instr == HALT_OP1));
    assign last_word = (rem_cnt == ADDR_W'(1));
    assign handshake = (state == S_EMIT) && dbus.out_ready;

`ifdef DUMP_ZERO_SKIP_EN
    assign skip_word = (dbus.mem_rdata == '0);
`else
    assign skip_word = 1'b0;
`endif

    // A skipped zero word advances the window straight from WAIT.
    assign advance = handshake || ((state == S_WAIT) && skip_word);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_RUN: begin
                if (halt_hit) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (drain_cnt == 8'd1) state_nxt = (rem_cnt == '0) ? S_DONE : S_READ;
            end
            S_READ: begin
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (skip_word) state_nxt = last_word ? S_DONE : S_READ;
                else           state_nxt = S_EMIT;
            end
            S_EMIT: begin
                if (handshake) state_nxt = last_word ? S_DONE : S_READ;
            end
            S_DONE: begin
                state_nxt = S_DONE;
            end
            default: begin
                state_nxt = S_RUN;
            end
        endcase
    end

    // Window registers and drain timer; base/count are captured only on the halt edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drain_cnt  <= '0;
            cur_addr   <= '0;
            rem_cnt    <= '0;
            out_addr_r <= '0;
            out_data_r <= '0;
            halted_r   <= 1'b0;
        end else begin
            if ((state == S_RUN) && halt_hit) begin
                drain_cnt <= 8'(DRAIN_CYCLES);
                cur_addr  <= dump_base;
                rem_cnt   <= dump_count;
                halted_r  <= 1'b1;
            end
            if (state == S_DRAIN) begin
                drain_cnt <= drain_cnt - 8'd1;
            end
            if ((state == S_WAIT) && !skip_word) begin
                out_addr_r <= cur_addr;
                out_data_r <= dbus.mem_rdata;
            end
            if (advance) begin
                cur_addr <= cur_addr + ADDR_W'(1);
                rem_cnt  <= rem_cnt - ADDR_W'(1);
            end
        end
    end

    assign cpu_stall      = (state != S_RUN);
    assign halted         = halted_r;
    assign done           = (state == S_DONE);
    assign dbus.mem_own   = (state == S_READ) || (state == S_WAIT) || (state == S_EMIT);
    assign dbus.mem_addr  = dbus.mem_own ? cur_addr : '0;
    assign dbus.out_valid = (state == S_EMIT);
    assign dbus.out_addr  = out_addr_r;
    assign dbus.out_data  = out_data_r;

endmodule

// File: tb/tb_halt_dump_controller.sv
// Scoreboard bench for halt_dump_controller: directed halts, expected words queued, monitor compares.
module tb_halt_dump_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] instr = '0;
    logic        instr_valid = 1'b0;
    logic [15:0] dump_base = '0;
    logic [15:0] dump_count = '0;
    logic        cpu_stall, halted, done;

    halt_dump_controller_if #(.ADDR_W(16), .DATA_W(16)) dbus ();

    halt_dump_controller dut (
        .clk        (clk),
        .reset      (reset),
        .instr      (instr),
        .instr_valid(instr_valid),
        .dump_base  (dump_base),
        .dump_count (dump_count),
        .cpu_stall  (cpu_stall),
        .halted     (halted),
        .done       (done),
        .dbus       (dbus)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [0:65535];
    always @(posedge clk) dbus.mem_rdata <= mem[dbus.mem_addr];

    int          checks = 0;
    int          failures = 0;
    int          hs_cnt = 0;
    logic        any_valid = 1'b0;
    logic [31:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: compares every presented word against the queue head, pops on handshake.
    always @(negedge clk) begin
        if (dbus.out_valid) any_valid = 1'b1;
        if (!reset && dbus.out_valid) begin
            if (exp_q.size() == 0) begin
                if (dbus.out_ready) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_word: got %h@%h expected none", dbus.out_data, dbus.out_addr);
                end
            end else begin
                checks++;
                if ({dbus.out_addr, dbus.out_data} !== exp_q[0]) begin
                    failures++;
                    $display("FAIL dump_word: got %h@%h expected %h@%h", dbus.out_data, dbus.out_addr,
                             exp_q[0][15:0], exp_q[0][31:16]);
                end
                if (dbus.out_ready) begin
                    void'(exp_q.pop_front());
                    hs_cnt++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        instr_valid = 1'b0;
        dbus.out_ready = 1'b0;
        exp_q.delete();
        repeat (2) step();
        reset = 1'b0;
        step();
        hs_cnt = 0;
        any_valid = 1'b0;
    endtask

    task automatic halt(input logic [15:0] op, input logic [15:0] base, input logic [15:0] cnt);
        instr = op;
        instr_valid = 1'b1;
        dump_base = base;
        dump_count = cnt;
        step();
        instr_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (!done && n < budget) begin
            step();
            n++;
        end
        chk({name, "_done"}, {31'd0, done}, 32'd1);
        chk({name, "_queue_empty"}, exp_q.size(), 32'd0);
    endtask

    task automatic run_bp(input int stall, input int budget);
        int n = 0;
        dbus.out_ready = 1'b0;
        while (!done && n < budget) begin
            if (dbus.out_valid) begin
                repeat (stall) step();
                dbus.out_ready = 1'b1;
                step();
                dbus.out_ready = 1'b0;
                n += stall + 1;
            end else begin
                step();
                n++;
            end
        end
    endtask

    initial begin
        dbus.out_ready = 1'b0;
        mem[1] = 16'h3C00;
        mem[4] = 16'd1; mem[5] = 16'd2; mem[6] = 16'd3;
        mem[8] = 16'd5; mem[9] = 16'd0; mem[10] = 16'd0; mem[11] = 16'd7;
        mem[16'hFFFE] = 16'hA1A1; mem[16'hFFFF] = 16'hA2A2; mem[0] = 16'hA3A3;

        // Reset state
        reset = 1'b1;
        #2;
        chk("reset_outputs", {cpu_stall, halted, done, dbus.mem_own, dbus.out_valid, dbus.mem_addr, dbus.out_addr[10:0]},
            32'd0);
        do_reset();

        // Halt detection and timing
        exp_q.push_back({16'd1, 16'h3C00});
        halt(16'hE000, 16'd1, 16'd1);
        chk("halted_c1", {31'd0, halted}, 32'd1);
        chk("stall_c1", {31'd0, cpu_stall}, 32'd1);
        for (int c = 2; c <= 13; c++) begin
            step();
            if (c == 10) chk("own_c10", {31'd0, dbus.mem_own}, 32'd0);
            if (c == 11) chk("read_c11", {dbus.mem_own, 15'd0, dbus.mem_addr}, {1'b1, 15'd0, 16'd1});
            if (c == 12) chk("valid_c12", {31'd0, dbus.out_valid}, 32'd0);
            if (c == 13) chk("valid_c13", {31'd0, dbus.out_valid}, 32'd1);
        end
        dbus.out_ready = 1'b1;
        wait_done("timing", 20);
        chk("done_own_released", {31'd0, dbus.mem_own}, 32'd0);

        // Invalid halt, then second encoding with an empty window
        do_reset();
        instr = 16'hE7FF;
        instr_valid = 1'b0;
        dump_count = 16'd0;
        repeat (3) step();
        chk("invalid_halt", {30'd0, halted, cpu_stall}, 32'd0);
        dbus.out_ready = 1'b1;
        halt(16'hE7FF, 16'd4, 16'd0);
        chk("halt_op1", {31'd0, halted}, 32'd1);
        repeat (9) step();
        chk("empty_done_c10", {31'd0, done}, 32'd0);
        step();
        chk("empty_done_c11", {31'd0, done}, 32'd1);
        repeat (3) step();
        chk("empty_no_valid", {31'd0, any_valid}, 32'd0);

        // Backpressure and stability
        do_reset();
        exp_q.push_back({16'd4, 16'd1});
        exp_q.push_back({16'd5, 16'd2});
        exp_q.push_back({16'd6, 16'd3});
        halt(16'hE000, 16'd4, 16'd3);
        run_bp(5, 200);
        chk("bp_done", {31'd0, done}, 32'd1);
        chk("bp_handshakes", hs_cnt, 32'd3);
        chk("bp_queue_empty", exp_q.size(), 32'd0);

        // Address wrap; halts and input changes after the halt edge are ignored
        do_reset();
        exp_q.push_back({16'hFFFE, 16'hA1A1});
        exp_q.push_back({16'hFFFF, 16'hA2A2});
        exp_q.push_back({16'h0000, 16'hA3A3});
        halt(16'hE000, 16'hFFFE, 16'd3);
        instr_valid = 1'b1;
        dump_base = 16'd8;
        dump_count = 16'd1;
        dbus.out_ready = 1'b1;
        wait_done("wrap", 60);
        instr_valid = 1'b0;
        chk("wrap_handshakes", hs_cnt, 32'd3);

        // Zero words
        do_reset();
        exp_q.push_back({16'd8, 16'd5});
`ifndef DUMP_ZERO_SKIP_EN
        exp_q.push_back({16'd9, 16'd0});
        exp_q.push_back({16'd10, 16'd0});
`endif
        exp_q.push_back({16'd11, 16'd7});
        halt(16'hE000, 16'd8, 16'd4);
        dbus.out_ready = 1'b1;
        wait_done("zero", 60);
`ifdef DUMP_ZERO_SKIP_EN
        chk("zero_handshakes", hs_cnt, 32'd2);
`else
        chk("zero_handshakes", hs_cnt, 32'd4);
`endif

        // Reset mid-dump, then restart from a new base
        do_reset();
        halt(16'hE000, 16'd4, 16'd3);
        begin
            int n = 0;
            while (!dbus.out_valid && n < 40) begin
                step();
                n++;
            end
        end
        chk("mid_valid", {31'd0, dbus.out_valid}, 32'd1);
        #3;
        reset = 1'b1;
        #1;
        chk("async_reset", {cpu_stall, halted, done, dbus.mem_own, dbus.out_valid, dbus.mem_addr[10:0], dbus.out_addr},
            32'd0);
        chk("async_reset_data", {16'd0, dbus.out_data}, 32'd0);
        step();
        reset = 1'b0;
        step();
        chk("after_reset_run", {30'd0, halted, cpu_stall}, 32'd0);
        exp_q.delete();
        hs_cnt = 0;
        exp_q.push_back({16'd1, 16'h3C00});
        halt(16'hE000, 16'd1, 16'd1);
        dbus.out_ready = 1'b1;
        wait_done("restart", 40);
        chk("restart_handshakes", hs_cnt, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/halt_dump_controller.md
Name: halt_dump_controller

Overview:
- Sequences end-of-program for the 16-bit pipelined CPU.
- Detects the halt instruction in the core's instruction stream and stalls fetch.
- Waits a fixed number of cycles so the pipeline drains, then takes ownership of the data-memory read port.
- Streams a configured address window out over a valid/ready port, for result capture and the regression dump.

Parameters:
- ADDR_W, 16, data-memory address width.
- DATA_W, 16, data-memory word and instruction width.
- DRAIN_CYCLES, 10, cycles between halt detection and the first memory read; legal range 1..255.
- HALT_OP0, 16'hE000, first halt encoding.
- HALT_OP1, 16'hE7FF, second halt encoding.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- instr  in  DATA_W  instruction currently in the core's decode stage.
- instr_valid  in  1  instr is a real, non-bubble instruction this cycle.
- dump_base  in  ADDR_W  first address to dump; sampled on halt detection.
- dump_count  in  ADDR_W  number of words to dump; sampled on halt detection.
- cpu_stall  out  1  freezes the core's PC and fetch.
- mem_own  out  1  data-memory port muxed to this block; core writes are blocked.
- mem_addr  out  ADDR_W  read address to data memory.
- mem_rdata  in  DATA_W  read data; valid exactly 1 cycle after mem_addr is presented.
- out_valid  out  1  dump word available.
- out_ready  in  1  consumer accepts the word.
- out_addr  out  ADDR_W  address of the dumped word.
- out_data  out  DATA_W  dumped word.
- halted  out  1  sticky; set on halt detection.
- done  out  1  sticky; dump complete.

Behaviour:
- Reset values: all outputs 0; state RUN; all counters 0.
- Reset is asynchronous. Asserting it mid-dump aborts immediately, returns to RUN and releases cpu_stall and mem_own.
- RUN:
  - Transition when instr_valid=1 and instr is HALT_OP0 or HALT_OP1.
  - On that edge: go to DRAIN, set halted and cpu_stall, latch base/count, load drain counter with DRAIN_CYCLES.
  - instr_valid=0 never triggers a halt, even if instr matches.
- DRAIN:
  - Counter decrements each cycle.
  - When it reaches 1, the next state is READ (if the latched count is nonzero) or DONE (if count is 0).
  - Result: first mem_addr is driven exactly DRAIN_CYCLES+1 cycles after the halt edge.
  - mem_own asserts on entry to READ and is held until DONE.
- READ: drive mem_addr = current address; go to WAIT.
- WAIT: capture mem_rdata into the out_data register, out_addr = current address; go to EMIT.
- EMIT:
  - out_valid=1; out_addr and out_data are held stable until out_valid && out_ready.
  - On handshake: address increments, remaining count decrements. Go to READ if words remain, otherwise DONE.
  - Throughput: one word per 3 cycles maximum.
  - out_valid never deasserts without a handshake.
- DONE:
  - done=1, halted=1, cpu_stall=1, mem_own=0, out_valid=0.
  - Terminal until reset.
- Address arithmetic is modulo 2^ADDR_W: base 16'hFFFE with count 3 dumps FFFE, FFFF, 0000.
- dump_count = 0 means an empty dump: DONE follows DRAIN with no out_valid.
- Halt encodings seen while not in RUN are ignored.
- dump_base and dump_count changes after the halt edge have no effect.

Optional Feature:
- Macro: DUMP_ZERO_SKIP_EN.
- Defined: in WAIT, a captured word equal to 0 is not emitted. Address increments, remaining count decrements, and the next state is READ or DONE directly. Zero words consume no handshake, and each zero word costs 2 cycles.
- Undefined: every word in the window is emitted, zeros included.

Test Plan:
- Halt detection and timing: instr=16'hE000, instr_valid=1 at cycle 0 with base=1, count=1 and memory[1]=16'h3C00 -> halted and cpu_stall rise at cycle 1, mem_addr=1 at cycle 11, out_valid with out_addr=1 and out_data=16'h3C00 at cycle 13, done after out_ready.
- Invalid halt and second encoding: instr=16'hE7FF with instr_valid=0 -> stays in RUN, halted=0. Same instr with instr_valid=1 -> halted=1.
- Backpressure and stability: base=4, count=3, memory[4..6]=1,2,3, out_ready low for 5 cycles on each word -> exactly three handshakes in order 1,2,3; out_data and out_addr stable while stalled.
- Wrap and empty window: base=16'hFFFE, count=3 -> out_addr sequence FFFE, FFFF, 0000. Separately, count=0 -> done with no out_valid.
- Zero skip: memory[8..11]=5,0,0,7, base=8, count=4 -> with DUMP_ZERO_SKIP_EN only 5@8 and 7@11 are emitted; without it, all four words are emitted.
- Reset mid-dump: assert reset in EMIT with out_valid high -> all outputs 0 asynchronously; after release, state is RUN and a new halt restarts the sequence from the newly latched base.
